hb_decim_tdm: RTL and testbench

HB_DECIM_TDM -- requirements
Module: hb_decim_tdm

---
 rtl/hb_pkg.sv | 40 ++++
 rtl/hb_decim_tdm_if.sv | 29 ++
 rtl/hb_coef_bank.sv | 53 +++++
 rtl/hb_decim_tdm.sv | 130 +++++++++++++
 tb/tb_hb_decim_tdm.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/hb_pkg.sv
// Shared constants, widths and default coefficients for the TDM halfband decimator.
// NTAPS = 4K-1 gives K distinct nonzero off-centre taps; centre tap is fixed at 0.5.
package hb_pkg;

    localparam int DEF_WIDTH  = 18;
    localparam int DEF_CWIDTH = 18;
    localparam int DEF_NTAPS  = 7;

    localparam int DEF_COEF_7 [2] = '{-4248, 37012};

    typedef enum logic [1:0] {ST_IDLE, ST_SNAP, ST_MAC, ST_DONE} hb_state_t;

    function automatic int taps_to_k(input int ntaps);
        return (ntaps + 1) / 4;
    endfunction

    function automatic int index_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    function automatic int acc_width(input int width, input int cwidth, input int k);
        return width + cwidth + $clog2(k) + 2;
    endfunction

    // 0.5 in coefficient format is 2^(cwidth-2); products carry cwidth-1 fraction bits.
    function automatic int centre_shift(input int cwidth);
        return cwidth - 2;
    endfunction

    function automatic int out_shift(input int cwidth);
        return cwidth - 1;
    endfunction

    function automatic int default_coef(input int ntaps, input int k);
        if (ntaps == 7 && k < 2)
            return DEF_COEF_7[k];
        return 0;
    endfunction

endpackage

// File: rtl/hb_decim_tdm_if.sv
// Sample, coefficient-load and result signals of the halfband decimator.
interface hb_decim_tdm_if
    import hb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CWIDTH = DEF_CWIDTH,
    parameter int AW     = 1
);
    logic                     in_en;
    logic signed [WIDTH-1:0]  x_in;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [CWIDTH-1:0] coef_data;
    logic                     coef_commit;
    logic signed [WIDTH-1:0]  y;
    logic                     out_valid;
    logic                     busy;
    logic                     ovf_err;

    modport master (
        output in_en, x_in, coef_we, coef_addr, coef_data, coef_commit,
        input  y, out_valid, busy, ovf_err
    );

    modport slave (
        input  in_en, x_in, coef_we, coef_addr, coef_data, coef_commit,
        output y, out_valid, busy, ovf_err
    );
endinterface

// File: rtl/hb_coef_bank.sv
// Shadow/active coefficient registers; a commit raised while a run holds the bank
// stays pending and lands once the hold drops.
module hb_coef_bank
    import hb_pkg::*;
#(
    parameter int CWIDTH = DEF_CWIDTH,
    parameter int NTAPS  = DEF_NTAPS,
    parameter int K      = taps_to_k(DEF_NTAPS),
    parameter int KW     = index_width(taps_to_k(DEF_NTAPS))
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [KW-1:0]            addr,
    input  logic signed [CWIDTH-1:0] data,
    input  logic                     commit,
    input  logic                     hold,
    input  logic [KW-1:0]            rd_idx,
    output logic signed [CWIDTH-1:0] rd_coef
);
    logic signed [CWIDTH-1:0] shadow      [K];
    logic signed [CWIDTH-1:0] shadow_next [K];
    logic signed [CWIDTH-1:0] active      [K];
    logic                     pending;
    logic                     apply;

    // A same-cycle write is folded in before the copy so a commit always sees it.
    always_comb begin
        for (int k = 0; k < K; k++)
            shadow_next[k] = (we && addr == KW'(k)) ? data : shadow[k];
        apply = (commit || pending) && !hold;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int k = 0; k < K; k++) begin
                shadow[k] <= CWIDTH'(default_coef(NTAPS, k));
                active[k] <= CWIDTH'(default_coef(NTAPS, k));
            end
            pending <= 1'b0;
        end else begin
            for (int k = 0; k < K; k++)
                shadow[k] <= shadow_next[k];
            if (apply)
                for (int k = 0; k < K; k++)
                    active[k] <= shadow_next[k];
            pending <= (commit || pending) && hold;
        end
    end

    assign rd_coef = active[rd_idx];

endmodule

// File: rtl/hb_decim_tdm.sv
// Decimate-by-2 halfband FIR: pre-added symmetric pairs share one multiplier over
// K cycles, the 0.5 centre tap is a shift, output is rounded and saturated.
module hb_decim_tdm
    import hb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CWIDTH = DEF_CWIDTH,
    parameter int NTAPS  = DEF_NTAPS
) (
    input logic           sys_clk,
    input logic           reset,
    hb_decim_tdm_if.slave bus
);
    localparam int K      = taps_to_k(NTAPS);
    localparam int KW     = index_width(K);
    localparam int ACCW   = acc_width(WIDTH, CWIDTH, K);
    localparam int PW     = WIDTH + 1;
    localparam int MW     = PW + CWIDTH;
    localparam int CENTRE = (NTAPS - 1) / 2;
    localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (out_shift(CWIDTH) - 1);
    localparam logic signed [ACCW-1:0] YMAX = (ACCW'(1) << (WIDTH - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

    hb_state_t               state, state_next;
    logic                    phase;
    logic                    accept;
    logic                    drop;
    logic                    run_hold;
    logic                    last_mac;
    logic signed [WIDTH-1:0] dline  [NTAPS];
    logic signed [PW-1:0]    snap_p [K];
    logic [KW-1:0]           idx;
    logic signed [CWIDTH-1:0] coef;
    logic signed [MW-1:0]    prod;
    logic signed [ACCW-1:0]  acc, acc_next, acc_rnd, acc_scaled;
    logic signed [WIDTH-1:0] y_sat, y_q;
    logic                    ovf_q;

    hb_coef_bank #(.CWIDTH(CWIDTH), .NTAPS(NTAPS), .K(K), .KW(KW)) coefs (
        .sys_clk (sys_clk),
        .reset   (reset),
        .we      (bus.coef_we),
        .addr    (bus.coef_addr),
        .data    (bus.coef_data),
        .commit  (bus.coef_commit),
        .hold    (run_hold),
        .rd_idx  (idx),
        .rd_coef (coef)
    );

    // A phase-1 sample cannot start a second run on top of one in flight.
    assign accept   = bus.in_en && !(phase && state != ST_IDLE);
    assign drop     = bus.in_en && phase && state != ST_IDLE;
    assign last_mac = (idx == KW'(K - 1));

    always_ff @(posedge sys_clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && phase) state_next = ST_SNAP;
            ST_SNAP: state_next = ST_MAC;
            ST_MAC:  if (last_mac) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == ST_DONE);
        bus.busy      = (state != ST_IDLE);
        run_hold      = (state == ST_SNAP) || (state == ST_MAC);
    end

    always_comb begin
        prod       = MW'(snap_p[idx]) * MW'(coef);
        acc_next   = acc + ACCW'(prod);
        acc_rnd    = acc_next + HALF;
        acc_scaled = acc_rnd >>> out_shift(CWIDTH);
        if (acc_scaled > YMAX)
            y_sat = YMAX[WIDTH-1:0];
        else if (acc_scaled < YMIN)
            y_sat = YMIN[WIDTH-1:0];
        else
            y_sat = acc_scaled[WIDTH-1:0];
    end

    // The snapshot reads the delay line before any same-edge shift, isolating the run.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            phase <= 1'b0;
            ovf_q <= 1'b0;
            idx   <= '0;
            acc   <= '0;
            y_q   <= '0;
            for (int i = 0; i < NTAPS; i++)
                dline[i] <= '0;
            for (int k = 0; k < K; k++)
                snap_p[k] <= '0;
        end else begin
            if (accept) begin
                dline[0] <= bus.x_in;
                for (int i = 1; i < NTAPS; i++)
                    dline[i] <= dline[i-1];
                phase <= ~phase;
            end
            if (drop)
                ovf_q <= 1'b1;
            if (state == ST_SNAP) begin
                for (int k = 0; k < K; k++)
                    snap_p[k] <= PW'(dline[2*k]) + PW'(dline[NTAPS-1-2*k]);
                acc <= ACCW'(dline[CENTRE]) <<< centre_shift(CWIDTH);
                idx <= '0;
            end else if (state == ST_MAC) begin
                acc <= acc_next;
                idx <= idx + KW'(1);
                if (last_mac)
                    y_q <= y_sat;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.ovf_err = ovf_q;

endmodule

// File: tb/tb_hb_decim_tdm.sv
// Directed bench for hb_decim_tdm (NTAPS=7, default coefficients) with
// hand-computed output sequences, latency, overflow and commit-timing checks.
module tb_hb_decim_tdm;

    logic sys_clk = 1'b0;
    logic reset;

    always #5 sys_clk = ~sys_clk;

    hb_decim_tdm_if #(.WIDTH(18), .CWIDTH(18), .AW(1)) bus ();

    hb_decim_tdm #(.WIDTH(18), .CWIDTH(18), .NTAPS(7)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc      = 0;
    logic   tb_phase = 1'b0;
    longint yq   [$];
    int     vcyc [$];
    int     p1q  [$];

    longint exp_t1 [4] = '{0, 32768, 0, 0};
    longint exp_t2 [5] = '{-2124, 18506, 18506, -2124, 0};

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Every out_valid pulse is logged with the cycle it was seen in.
    always @(negedge sys_clk) begin
        if (bus.out_valid) begin
            yq.push_back(longint'(bus.y));
            vcyc.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint y_at(input int i);
        return (i < yq.size()) ? yq[i] : 64'sd999999999;
    endfunction

    function automatic longint lat_at(input int i);
        return (i < vcyc.size() && i < p1q.size()) ? longint'(vcyc[i] - p1q[i]) : -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input logic en, input logic signed [17:0] x);
        bus.in_en = en;
        bus.x_in  = x;
        @(negedge sys_clk);
        bus.in_en = 1'b0;
        bus.x_in  = '0;
    endtask

    task automatic feedSample(input logic signed [17:0] x);
        if (tb_phase)
            p1q.push_back(cyc);
        applyStimulus(1'b1, x);
        idle(2);
        tb_phase = ~tb_phase;
    endtask

    task automatic writeCoef(input logic we, input logic [0:0] addr,
                             input logic signed [17:0] data, input logic commit);
        bus.coef_we     = we;
        bus.coef_addr   = addr;
        bus.coef_data   = data;
        bus.coef_commit = commit;
        @(negedge sys_clk);
        bus.coef_we     = 1'b0;
        bus.coef_commit = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        yq.delete();
        vcyc.delete();
        p1q.delete();
        tb_phase = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_en       = 1'b0;
        bus.x_in        = '0;
        bus.coef_we     = 1'b0;
        bus.coef_addr   = '0;
        bus.coef_data   = '0;
        bus.coef_commit = 1'b0;
        idle(3);
        checkOutput("rst_y", longint'(bus.y), 0);
        checkOutput("rst_out_valid", longint'(bus.out_valid), 0);
        checkOutput("rst_busy", longint'(bus.busy), 0);
        checkOutput("rst_ovf", longint'(bus.ovf_err), 0);
        reset = 1'b0;

        $display("[TB] impulse on phase 0");
        doReset();
        feedSample(18'sd65536);
        repeat (7) feedSample(18'sd0);
        idle(8);
        checkOutput("t1_count", longint'(yq.size()), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t1_y%0d", i), y_at(i), exp_t1[i]);
            checkOutput($sformatf("t1_lat%0d", i), lat_at(i), 4);
        end

        $display("[TB] impulse on phase 1");
        doReset();
        feedSample(18'sd0);
        applyStimulus(1'b1, 18'sd65536);
        tb_phase = 1'b0;
        checkOutput("t2_busy_first", longint'(bus.busy), 1);
        idle(3);
        checkOutput("t2_valid_at_k2", longint'(bus.out_valid), 1);
        checkOutput("t2_busy_at_valid", longint'(bus.busy), 1);
        checkOutput("t2_y_at_valid", longint'(bus.y), -2124);
        idle(1);
        checkOutput("t2_busy_after", longint'(bus.busy), 0);
        checkOutput("t2_valid_after", longint'(bus.out_valid), 0);
        repeat (8) feedSample(18'sd0);
        idle(8);
        checkOutput("t2_count", longint'(yq.size()), 5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("t2_y%0d", i), y_at(i), exp_t2[i]);

        $display("[TB] constant positive input");
        doReset();
        repeat (8) feedSample(18'sd131071);
        idle(8);
        checkOutput("t3_count", longint'(yq.size()), 4);
        checkOutput("t3_steady", y_at(3), 131063);

        $display("[TB] saturation with larger h[2]");
        doReset();
        writeCoef(1'b1, 1'b1, 18'sd65535, 1'b1);
        repeat (8) feedSample(18'sd131071);
        idle(8);
        checkOutput("t4_sat_pos", y_at(3), 131071);
        doReset();
        writeCoef(1'b1, 1'b1, 18'sd65535, 1'b0);
        writeCoef(1'b0, 1'b0, 18'sd0, 1'b1);
        repeat (8) feedSample(-18'sd131072);
        idle(8);
        checkOutput("t4_sat_neg", y_at(3), -131072);

        $display("[TB] dropped phase-1 sample");
        doReset();
        applyStimulus(1'b1, 18'sd0);
        applyStimulus(1'b1, 18'sd65536);
        applyStimulus(1'b1, 18'sd0);
        checkOutput("t5_ovf_before", longint'(bus.ovf_err), 0);
        applyStimulus(1'b1, 18'sd65536);
        idle(3);
        checkOutput("t5_ovf_set", longint'(bus.ovf_err), 1);
        tb_phase = 1'b1;
        repeat (5) feedSample(18'sd0);
        idle(8);
        checkOutput("t5_ovf_sticky", longint'(bus.ovf_err), 1);
        checkOutput("t5_count", longint'(yq.size()), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t5_y%0d", i), y_at(i), exp_t2[i]);
        doReset();
        checkOutput("t5_ovf_cleared", longint'(bus.ovf_err), 0);

        $display("[TB] commit while busy");
        doReset();
        applyStimulus(1'b1, 18'sd0);
        applyStimulus(1'b1, 18'sd65536);
        writeCoef(1'b1, 1'b0, 18'sd8192, 1'b1);
        idle(5);
        applyStimulus(1'b1, 18'sd0);
        applyStimulus(1'b1, 18'sd65536);
        idle(8);
        checkOutput("t6_count", longint'(yq.size()), 2);
        checkOutput("t6_old_coef", y_at(0), -2124);
        checkOutput("t6_new_coef", y_at(1), 22602);

        $display("[TB] reset mid-run");
        doReset();
        applyStimulus(1'b1, 18'sd0);
        applyStimulus(1'b1, 18'sd65536);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(8);
        checkOutput("t7_no_valid", longint'(yq.size()), 0);
        checkOutput("t7_y", longint'(bus.y), 0);
        checkOutput("t7_busy", longint'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
